// File: rtl/fp_pipe_pkg.sv
// Shared FP pipeline definitions: OP-FP opcode, funct7 codes for the
// single-precision arithmetic subset, and the decoded operation type.
package fp_pipe_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 8;

    localparam logic [6:0] OPCODE_OPFP = 7'b1010011;

    localparam logic [6:0] F7_ADD = 7'd0;
    localparam logic [6:0] F7_SUB = 7'd4;
    localparam logic [6:0] F7_MUL = 7'd8;
    localparam logic [6:0] F7_DIV = 7'd12;

    typedef enum logic [1:0] {
        FP_ADD = 2'd0,
        FP_SUB = 2'd1,
        FP_MUL = 2'd2,
        FP_DIV = 2'd3
    } fp_op_t;

endpackage

// File: rtl/fp_scoreboard.sv
// Per-register busy bits. A set and a clear of the same register in one
// cycle leaves it busy, since the set marks a newly issued producer.
module fp_scoreboard #(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] q1_addr,
    output logic          q1_busy,
    input  logic [AW-1:0] q2_addr,
    output logic          q2_busy
);

    logic [NREGS-1:0] busy_q;

    // Busy bit update; the set is applied last so it wins over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            if (clr_en) busy_q[clr_addr] <= 1'b0;
            if (set_en) busy_q[set_addr] <= 1'b1;
        end
    end

    assign q1_busy = busy_q[q1_addr];
    assign q2_busy = busy_q[q2_addr];

endmodule

// File: rtl/fp_decode_stage.sv
// FP decode stage: decodes fadd.s/fsub.s/fmul.s/fdiv.s, reads operands,
// tracks RAW hazards with a busy scoreboard and registers the result for
// execute. Optional macro FP_DEC_WB_BYPASS_EN forwards the writeback value
// into operand capture and removes the hazard on a source being retired.
module fp_decode_stage
    import fp_pipe_pkg::*;
#(
    parameter int XLEN  = fp_pipe_pkg::XLEN,
    parameter int PC_W  = fp_pipe_pkg::PC_W,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            if_valid,
    input  logic [31:0]     if_instruction,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            wb_valid,
    input  logic            wb_reg_write_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] op1_out,
    output logic [XLEN-1:0] op2_out,
    output logic [4:0]      rd_out,
    output logic [1:0]      fp_op_out,
    output logic            decode_valid_out,
    output logic [31:0]     decode_instruction_out,
    output logic [PC_W-1:0] decode_pc_out,
    output logic            halted,
    output logic            illegal_pulse
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            legal;
    logic            is_zero;
    logic            wb_clr;
    logic            byp1;
    logic            byp2;
    logic            busy1;
    logic            busy2;
    logic            hazard;
    logic            accept;
    logic            issue;
    logic [XLEN-1:0] op1_nxt;
    logic [XLEN-1:0] op2_nxt;
    fp_op_t          fp_op_q;

    assign opcode      = if_instruction[6:0];
    assign rd          = if_instruction[11:7];
    assign funct3      = if_instruction[14:12];
    assign funct7      = if_instruction[31:25];
    assign rf_rs1_addr = if_instruction[19:15];
    assign rf_rs2_addr = if_instruction[24:20];

    assign legal   = (opcode == OPCODE_OPFP) && (funct3 == 3'b000) &&
                     ((funct7 == F7_ADD) || (funct7 == F7_SUB) ||
                      (funct7 == F7_MUL) || (funct7 == F7_DIV));
    assign is_zero = (if_instruction == 32'd0);
    assign wb_clr  = wb_valid && wb_reg_write_en;

`ifdef FP_DEC_WB_BYPASS_EN
    assign byp1    = wb_clr && (wb_rd == rf_rs1_addr);
    assign byp2    = wb_clr && (wb_rd == rf_rs2_addr);
    assign op1_nxt = byp1 ? wb_result : rf_rs1_data;
    assign op2_nxt = byp2 ? wb_result : rf_rs2_data;
`else
    logic unused_wb;
    assign byp1      = 1'b0;
    assign byp2      = 1'b0;
    assign op1_nxt   = rf_rs1_data;
    assign op2_nxt   = rf_rs2_data;
    assign unused_wb = ^wb_result;
`endif

    assign hazard   = (busy1 && !byp1) || (busy2 && !byp2);
    assign if_ready = !stall && !halted && !(legal && hazard);
    assign accept   = if_valid && if_ready;
    assign issue    = accept && legal;

    fp_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (issue),
        .set_addr (rd),
        .clr_en   (wb_clr),
        .clr_addr (wb_rd),
        .q1_addr  (rf_rs1_addr),
        .q1_busy  (busy1),
        .q2_addr  (rf_rs2_addr),
        .q2_busy  (busy2)
    );

    // Execute-facing pipeline register; frozen while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decode_valid_out       <= 1'b0;
            op1_out                <= '0;
            op2_out                <= '0;
            rd_out                 <= '0;
            fp_op_q                <= FP_ADD;
            decode_instruction_out <= '0;
            decode_pc_out          <= '0;
        end else if (!stall) begin
            decode_valid_out <= issue;
            if (issue) begin
                op1_out                <= op1_nxt;
                op2_out                <= op2_nxt;
                rd_out                 <= rd;
                fp_op_q                <= fp_op_t'(funct7[3:2]);
                decode_instruction_out <= if_instruction;
                decode_pc_out          <= if_pc;
            end
        end
    end

    assign fp_op_out = fp_op_q;

    // Status: sticky halt on the all-zero word, one-cycle illegal pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted        <= 1'b0;
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= accept && !legal && !is_zero;
            if (accept && is_zero) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_decode_stage.sv
// Directed bench for fp_decode_stage; expectations follow the bypass macro.
module tb_fp_decode_stage;
    import fp_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [7:0]  if_pc;
    logic        if_ready;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic        wb_valid;
    logic        wb_reg_write_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] op1_out;
    logic [31:0] op2_out;
    logic [4:0]  rd_out;
    logic [1:0]  fp_op_out;
    logic        decode_valid_out;
    logic [31:0] decode_instruction_out;
    logic [7:0]  decode_pc_out;
    logic        halted;
    logic        illegal_pulse;

    logic [31:0] rf [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign rf_rs1_data = rf[rf_rs1_addr];
    assign rf_rs2_data = rf[rf_rs2_addr];

    always @(posedge clk) if (wb_valid && wb_reg_write_en) rf[wb_rd] <= wb_result;

    fp_decode_stage dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall                  (stall),
        .if_valid               (if_valid),
        .if_instruction         (if_instruction),
        .if_pc                  (if_pc),
        .if_ready               (if_ready),
        .rf_rs1_addr            (rf_rs1_addr),
        .rf_rs2_addr            (rf_rs2_addr),
        .rf_rs1_data            (rf_rs1_data),
        .rf_rs2_data            (rf_rs2_data),
        .wb_valid               (wb_valid),
        .wb_reg_write_en        (wb_reg_write_en),
        .wb_rd                  (wb_rd),
        .wb_result              (wb_result),
        .op1_out                (op1_out),
        .op2_out                (op2_out),
        .rd_out                 (rd_out),
        .fp_op_out              (fp_op_out),
        .decode_valid_out       (decode_valid_out),
        .decode_instruction_out (decode_instruction_out),
        .decode_pc_out          (decode_pc_out),
        .halted                 (halted),
        .illegal_pulse          (illegal_pulse)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, OPCODE_OPFP};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [7:0] pc);
        if_valid       = 1'b1;
        if_instruction = instr;
        if_pc          = pc;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] r, input logic [31:0] v);
        wb_valid        = en;
        wb_reg_write_en = en;
        wb_rd           = r;
        wb_result       = v;
    endtask

    logic [6:0] t3_f7  [4] = '{F7_ADD, F7_SUB, F7_MUL, F7_DIV};
    logic [4:0] t3_rd  [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    logic [4:0] t3_rs1 [4] = '{5'd1, 5'd1, 5'd2, 5'd7};
    logic [4:0] t3_rs2 [4] = '{5'd2, 5'd2, 5'd1, 5'd8};

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h3F800000 + i;
        rf[1] = 32'h40490FD0;
        rf[2] = 32'h402DF84D;
        rf[7] = 32'h41000000;
        rf[8] = 32'h40000000;
        reset = 1'b0;
        stall = 1'b0;
        if_valid = 1'b0;
        if_instruction = '0;
        if_pc = '0;
        set_wb(1'b0, 5'd0, 32'd0);

        // Reset state
        #12;
        chk("rst_valid", decode_valid_out, 0);
        chk("rst_op1", op1_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_busy", dut.u_sb.busy_q, 0);
        @(negedge clk) reset = 1'b1;
        tick;

        // 1: basic fadd
        drive(enc(F7_ADD, 5'd3, 5'd1, 5'd2), 8'h10);
        #1;
        chk("t1_ready", if_ready, 1);
        chk("t1_rs1a", rf_rs1_addr, 1);
        chk("t1_rs2a", rf_rs2_addr, 2);
        tick;
        chk("t1_valid", decode_valid_out, 1);
        chk("t1_op1", op1_out, 32'h40490FD0);
        chk("t1_op2", op2_out, 32'h402DF84D);
        chk("t1_rd", rd_out, 3);
        chk("t1_fpop", fp_op_out, 0);
        chk("t1_pc", decode_pc_out, 8'h10);
        chk("t1_instr", decode_instruction_out, enc(F7_ADD, 5'd3, 5'd1, 5'd2));
        chk("t1_busy3", dut.u_sb.busy_q[3], 1);

        // 2: dependent fmul r5,r3,r2
        drive(enc(F7_MUL, 5'd5, 5'd3, 5'd2), 8'h14);
        #1;
        chk("t2_ready_haz", if_ready, 0);
        tick;
        chk("t2_bubble", decode_valid_out, 0);
        set_wb(1'b1, 5'd3, 32'h40B00000);
        #1;
`ifdef FP_DEC_WB_BYPASS_EN
        chk("t2_ready_wb", if_ready, 1);
`else
        chk("t2_ready_wb", if_ready, 0);
        tick;
        set_wb(1'b0, 5'd0, 32'd0);
        chk("t2_bubble_wb", decode_valid_out, 0);
        #1;
        chk("t2_ready_after", if_ready, 1);
`endif
        tick;
        set_wb(1'b0, 5'd0, 32'd0);
        if_valid = 1'b0;
        chk("t2_valid", decode_valid_out, 1);
        chk("t2_op1", op1_out, 32'h40B00000);
        chk("t2_op2", op2_out, 32'h402DF84D);
        chk("t2_rd", rd_out, 5);
        chk("t2_fpop", fp_op_out, 2);
        chk("t2_busy3", dut.u_sb.busy_q[3], 0);
        chk("t2_busy5", dut.u_sb.busy_q[5], 1);

        // 3: four independent ops back to back
        for (int i = 0; i < 4; i++) begin
            drive(enc(t3_f7[i], t3_rd[i], t3_rs1[i], t3_rs2[i]), 8'h20 + 8'(i));
            #1;
            chk($sformatf("t3_ready%0d", i), if_ready, 1);
            tick;
            chk($sformatf("t3_valid%0d", i), decode_valid_out, 1);
            chk($sformatf("t3_fpop%0d", i), fp_op_out, 64'(i));
            chk($sformatf("t3_rd%0d", i), rd_out, t3_rd[i]);
            chk($sformatf("t3_op1_%0d", i), op1_out, rf[t3_rs1[i]]);
            chk($sformatf("t3_op2_%0d", i), op2_out, rf[t3_rs2[i]]);
        end
        if_valid = 1'b0;

        // 4: stall window with a writeback to r3
        drive(enc(F7_ADD, 5'd3, 5'd1, 5'd2), 8'h40);
        tick;
        chk("t4_issue", rd_out, 3);
        stall = 1'b1;
        drive(enc(F7_SUB, 5'd14, 5'd1, 5'd2), 8'h44);
        set_wb(1'b1, 5'd3, 32'h3F000000);
        #1;
        chk("t4_ready_stall", if_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            set_wb(1'b0, 5'd0, 32'd0);
            chk($sformatf("t4_frz_valid%0d", i), decode_valid_out, 1);
            chk($sformatf("t4_frz_rd%0d", i), rd_out, 3);
            chk($sformatf("t4_frz_pc%0d", i), decode_pc_out, 8'h40);
        end
        chk("t4_busy3", dut.u_sb.busy_q[3], 0);
        chk("t4_busy14", dut.u_sb.busy_q[14], 0);
        stall = 1'b0;
        #1;
        chk("t4_ready", if_ready, 1);
        tick;
        if_valid = 1'b0;
        chk("t4_valid", decode_valid_out, 1);
        chk("t4_rd", rd_out, 14);
        chk("t4_fpop", fp_op_out, 1);
        tick;
        chk("t4_nodup", decode_valid_out, 0);

        // 6: asynchronous reset with busy[6] and valid output
        drive(enc(F7_ADD, 5'd6, 5'd1, 5'd2), 8'h50);
        tick;
        if_valid = 1'b0;
        chk("t6_valid", decode_valid_out, 1);
        chk("t6_busy6", dut.u_sb.busy_q[6], 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", decode_valid_out, 0);
        chk("t6_rst_op1", op1_out, 0);
        chk("t6_rst_rd", rd_out, 0);
        chk("t6_rst_pc", decode_pc_out, 0);
        chk("t6_rst_busy", dut.u_sb.busy_q, 0);
        @(negedge clk) reset = 1'b1;
        drive(enc(F7_DIV, 5'd6, 5'd7, 5'd8), 8'h60);
        #1;
        chk("t6_ready", if_ready, 1);
        tick;
        if_valid = 1'b0;
        chk("t6_div_valid", decode_valid_out, 1);
        chk("t6_div_fpop", fp_op_out, 3);
        chk("t6_div_op1", op1_out, 32'h41000000);
        chk("t6_div_op2", op2_out, 32'h40000000);
        chk("t6_div_rd", rd_out, 6);

        // 5: illegal instruction, then halt
        drive(32'h00000033, 8'h70);
        #1;
        chk("t5_ill_ready", if_ready, 1);
        tick;
        if_valid = 1'b0;
        chk("t5_ill_pulse", illegal_pulse, 1);
        chk("t5_ill_valid", decode_valid_out, 0);
        tick;
        chk("t5_ill_pulse_end", illegal_pulse, 0);
        drive(32'h00000000, 8'h74);
        tick;
        chk("t5_halted", halted, 1);
        chk("t5_halt_valid", decode_valid_out, 0);
        chk("t5_halt_pulse", illegal_pulse, 0);
        drive(enc(F7_ADD, 5'd20, 5'd1, 5'd2), 8'h78);
        #1;
        chk("t5_halt_ready", if_ready, 0);
        tick;
        chk("t5_halt_noissue", decode_valid_out, 0);
        tick;
        chk("t5_halt_sticky", halted, 1);
        if_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
